// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock, with round keys
// fetched combinationally from an external key store addressed by rk_idx.
module aes_inv_cipher_iter #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDK  = 3'd1;
  localparam logic [2:0] ROUND = 3'd2;
  localparam logic [2:0] FINAL = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [3:0] NR_IDX   = 4'(NR);
  localparam logic [3:0] LAST_CNT = 4'(NR - 1);

  logic [2:0]   fsm_q, fsm_d;
  logic [127:0] data_q, data_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] sb_sr;
  logic         accept;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    return gmul(x252, x2);
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a;
    a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return ginv(a);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign in_ready  = !rst && ((fsm_q == IDLE) || ((fsm_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (fsm_q == DONE);
  assign out_data  = out_valid ? data_q : '0;
  assign busy      = (fsm_q == ADDK) || (fsm_q == ROUND) || (fsm_q == FINAL);

  always_comb begin
    fsm_d  = fsm_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    rk_idx = NR_IDX;
    sb_sr  = inv_sub_bytes(inv_shift_rows(data_q));
    case (fsm_q)
      IDLE: begin
        if (accept) begin
          data_d = in_data;
          cnt_d  = LAST_CNT;
          fsm_d  = ADDK;
        end
      end
      ADDK: begin
        data_d = data_q ^ rk;
        fsm_d  = ROUND;
      end
      ROUND: begin
        rk_idx = cnt_q;
        data_d = inv_mix_columns(sb_sr ^ rk);
        if (cnt_q == 4'd1) fsm_d = FINAL;
        else               cnt_d = cnt_q - 4'd1;
      end
      FINAL: begin
        rk_idx = '0;
        data_d = sb_sr ^ rk;
        fsm_d  = DONE;
      end
      DONE: begin
        // A waiting block is taken on the same edge the result is consumed.
        if (accept) begin
          data_d = in_data;
          cnt_d  = LAST_CNT;
          fsm_d  = ADDK;
        end else if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= IDLE;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: NR=10 and NR=14 instances checked every cycle
// against a phase-level model and a byte-array FIPS-197 inverse cipher.
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_STD = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid[2], in_ready[2], out_valid[2], out_ready[2], busy[2];
  logic [127:0] in_data[2], out_data[2], rk[2];
  logic [3:0]   rk_idx[2];
  logic [127:0] ks[2][16];
  logic [7:0]   sb[256], isb[256];
  int           passed = 0, total = 0;
  int           nr_of[2] = '{10, 14};
  int           m_ph[2]  = '{-1, -1};   // -1 idle, 0..NR in flight, NR+1 result held
  logic [127:0] m_exp[2];
  bit           m_clean[2] = '{1'b1, 1'b1};

  always #5 clk = ~clk;

  aes_inv_cipher_iter #(.NR(10)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .rk_idx(rk_idx[0]), .rk(rk[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
  );

  aes_inv_cipher_iter #(.NR(14)) dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .rk_idx(rk_idx[1]), .rk(rk[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
  );

  assign rk[0] = ks[0][rk_idx[0]];
  assign rk[1] = ks[1][rk_idx[1]];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sboxes();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  // Standard key expansion; key is left-aligned in 256 bits.
  task automatic set_keys(input int u, input logic [255:0] key);
    logic [31:0] w[60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nr = nr_of[u];
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ks[u][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [7:0] kb(input int u, input int rnd, input int idx);
    logic [127:0] k;
    k = ks[u][rnd];
    return k[127-8*idx -: 8];
  endfunction

  function automatic logic [127:0] inv_cipher(input logic [127:0] ct, input int u);
    logic [7:0]   s[4][4];
    logic [7:0]   t[4][4];
    logic [127:0] res;
    int nr;
    nr = nr_of[u];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = ct[127-8*(4*c+r) -: 8] ^ kb(u, nr, 4*c+r);
    for (int rnd = nr - 1; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = isb[s[r][(c+4-r)%4]] ^ kb(u, rnd, 4*c+r);
      for (int c = 0; c < 4; c++) begin
        if (rnd > 0) begin
          s[0][c] = gm(8'h0e, t[0][c]) ^ gm(8'h0b, t[1][c]) ^ gm(8'h0d, t[2][c]) ^ gm(8'h09, t[3][c]);
          s[1][c] = gm(8'h09, t[0][c]) ^ gm(8'h0e, t[1][c]) ^ gm(8'h0b, t[2][c]) ^ gm(8'h0d, t[3][c]);
          s[2][c] = gm(8'h0d, t[0][c]) ^ gm(8'h09, t[1][c]) ^ gm(8'h0e, t[2][c]) ^ gm(8'h0b, t[3][c]);
          s[3][c] = gm(8'h0b, t[0][c]) ^ gm(8'h0d, t[1][c]) ^ gm(8'h09, t[2][c]) ^ gm(8'h0e, t[3][c]);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
        end
      end
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic bit m_ready(input int u);
    return !rst && (m_ph[u] == -1 || (m_ph[u] == nr_of[u] + 1 && out_ready[u]));
  endfunction

  task automatic model_step(input int u);
    if (rst) begin
      m_ph[u]    = -1;
      m_clean[u] = 1'b1;
    end else if (in_valid[u] && m_ready(u)) begin
      m_ph[u]    = 0;
      m_exp[u]   = inv_cipher(in_data[u], u);
      m_clean[u] = 1'b0;
    end else if (m_ph[u] == nr_of[u] + 1) begin
      if (out_ready[u]) m_ph[u] = -1;
    end else if (m_ph[u] >= 0) begin
      m_ph[u]++;
    end
  endtask

  task automatic compare(input int u);
    int  ph, nr;
    bit  inflight;
    ph = m_ph[u];
    nr = nr_of[u];
    inflight = (ph >= 0 && ph <= nr);
    check($sformatf("u%0d out_valid", u), out_valid[u], (ph == nr + 1));
    check($sformatf("u%0d busy", u), busy[u], inflight);
    check($sformatf("u%0d rk_idx", u), rk_idx[u], inflight ? 128'(nr - ph) : 128'(nr));
    check($sformatf("u%0d in_ready", u), in_ready[u], m_ready(u));
    if (ph == nr + 1) check($sformatf("u%0d out_data", u), out_data[u], m_exp[u]);
    else if (m_clean[u]) check($sformatf("u%0d out_data idle", u), out_data[u], '0);
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    #2;
    compare(0);
    compare(1);
  end

  // Called at posedge+2 right after the accepting edge; returns at posedge+2 of the result.
  task automatic wait_done(input int u, input int lat, input string tag);
    int n;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #2;
      n++;
      if (n <= nr_of[u]) check({tag, " rk_idx seq"}, rk_idx[u], 128'(nr_of[u] - n));
      if (out_valid[u]) break;
    end
    check({tag, " latency"}, 128'(n), 128'(lat));
  endtask

  task automatic run_block(input int u, input logic [127:0] ct, input logic [127:0] pt,
                           input int lat, input string tag);
    @(negedge clk);
    in_data[u]  = ct;
    in_valid[u] = 1'b1;
    @(posedge clk);
    #2;
    check({tag, " accepted"}, busy[u], 1'b1);
    check({tag, " rk_idx first"}, rk_idx[u], 128'(nr_of[u]));
    @(negedge clk);
    in_valid[u] = 1'b0;
    wait_done(u, lat, tag);
    check({tag, " plaintext"}, out_data[u], pt);
  endtask

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      in_valid[u]  = 1'b0;
      out_ready[u] = 1'b1;
      in_data[u]   = '0;
      for (int r = 0; r < 16; r++) ks[u][r] = '0;
    end
    build_sboxes();
    check("model sbox[00]", sb[0], 8'h63);
    check("model sbox[53]", sb[8'h53], 8'hed);
    check("model isbox[00]", isb[0], 8'h52);
    check("model isbox[63]", isb[8'h63], 8'h00);
    set_keys(0, {C1_KEY, 128'h0});
    check("model C1 rk10", ks[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("model C1 decrypt", inv_cipher(C1_CT, 0), PT_STD);

    // Reset state while rst is held
    @(negedge clk);
    check("reset busy", busy[0], 1'b0);
    check("reset out_valid", out_valid[0], 1'b0);
    check("reset out_data", out_data[0], '0);
    check("reset in_ready", in_ready[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("in_ready after reset", in_ready[0], 1'b1);

    run_block(0, C1_CT, PT_STD, 11, "C1");

    set_keys(0, {B_KEY, 128'h0});
    check("model B rk10", ks[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("model B decrypt", inv_cipher(B_CT, 0), B_PT);
    run_block(0, B_CT, B_PT, 11, "B");

    // Backpressure with a second block waiting
    @(negedge clk);
    @(negedge clk);
    set_keys(0, {C1_KEY, 128'h0});
    out_ready[0] = 1'b0;
    run_block(0, C1_CT, PT_STD, 11, "bp1");
    @(negedge clk);
    set_keys(0, {B_KEY, 128'h0});
    in_data[0]  = B_CT;
    in_valid[0] = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #2;
      check("bp hold out_valid", out_valid[0], 1'b1);
      check("bp hold out_data", out_data[0], PT_STD);
      check("bp hold in_ready", in_ready[0], 1'b0);
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    @(posedge clk);
    #2;
    check("bp accept on release", busy[0], 1'b1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    wait_done(0, 11, "bp2");
    check("bp2 plaintext", out_data[0], B_PT);

    // Back-to-back: in_valid never drops between the two blocks
    set_keys(0, {C1_KEY, 128'h0});
    @(negedge clk);
    in_data[0]  = C1_CT;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #2;
    check("b2b1 accepted", busy[0], 1'b1);
    wait_done(0, 11, "b2b1");
    check("b2b1 plaintext", out_data[0], PT_STD);
    @(negedge clk);
    set_keys(0, {B_KEY, 128'h0});
    in_data[0] = B_CT;
    @(posedge clk);
    #2;
    check("b2b no idle gap", busy[0], 1'b1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    wait_done(0, 11, "b2b2");
    check("b2b2 plaintext", out_data[0], B_PT);

    // Reset during round 5
    set_keys(0, {C1_KEY, 128'h0});
    @(negedge clk);
    in_data[0]  = C1_CT;
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre-reset busy", busy[0], 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("mid reset busy", busy[0], 1'b0);
    check("mid reset out_valid", out_valid[0], 1'b0);
    check("mid reset out_data", out_data[0], '0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("mid reset in_ready", in_ready[0], 1'b1);
    run_block(0, C1_CT, PT_STD, 11, "post-reset C1");

    // NR=14 instance, AES-256
    set_keys(1, C3_KEY);
    check("model C3 decrypt", inv_cipher(C3_CT, 1), PT_STD);
    run_block(1, C3_CT, PT_STD, 15, "C3");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative AES inverse cipher (decryption datapath) for the project's AES block; it is the receive-side counterpart of the encryption round chain.
- Executes one inverse round per clock, using InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns.
- Takes a 128-bit ciphertext over a valid/ready handshake and returns the plaintext over a valid/ready handshake.
- Round keys come from an external key store: the block drives the index, and the store returns the key combinationally in the same cycle.

Parameters:
- NR, 10, number of rounds. Legal values are 10, 12 and 14; the rk_idx range follows NR.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ciphertext present on in_data.
- in_ready  out  1  block can accept a ciphertext.
- in_data  in  128  ciphertext; bits [127:120] are state byte 0 (column-major, same byte order as the encryption path).
- rk_idx  out  4  index of the round key required this cycle.
- rk  in  128  round key rk_idx, valid in the same cycle (combinational lookup).
- out_valid  out  1  plaintext present on out_data.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  128  plaintext, same byte order as in_data.
- busy  out  1  high in ADDK, ROUND and FINAL.

Behaviour:
- Reset applies whenever rst=1 at a clock edge, including mid-operation. Reset state: FSM=IDLE, state register=0, round counter=0, out_valid=0, out_data=0, busy=0.
- in_ready is forced to 0 while rst=1.
- FSM states are IDLE, ADDK, ROUND, FINAL and DONE.
- in_ready = !rst && (IDLE || (DONE && out_ready)).
- Accept condition is in_valid && in_ready: state register <= in_data, round counter <= NR-1, FSM -> ADDK.
- ADDK: rk_idx = NR; state <= state ^ rk; FSM -> ROUND.
- ROUND: rk_idx = counter. Next state = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk)).
  - If counter == 1, FSM -> FINAL; otherwise counter decrements by 1.
- FINAL: rk_idx = 0; state <= InvSubBytes(InvShiftRows(state)) ^ rk; FSM -> DONE.
- DONE: out_valid = 1 and out_data = state register.
  - out_data stays stable while out_ready = 0.
  - On out_ready = 1: if in_valid = 1 at the same edge, the new block is accepted (FSM -> ADDK, back-to-back); otherwise FSM -> IDLE.
- rk_idx is NR in IDLE and DONE. rk is ignored outside ADDK, ROUND and FINAL.
- Latency: out_valid rises NR+1 clock edges after the accepting edge (11 for NR=10).
- Throughput: one block per NR+1 cycles when out_ready is held high.
- in_valid while busy: no effect. in_data is not sampled and in_ready stays 0.
- out_valid is a registered output: it is 1 exactly when FSM=DONE, with no combinational path from inputs.
- Round transforms follow FIPS-197:
  - InvShiftRows rotates row r right by r bytes.
  - InvSubBytes uses the inverse S-box.
  - InvMixColumns uses the matrix {0e,0b,0d,09} over GF(2^8), reduction polynomial 0x11b.
- The round counter is 4 bits. It never wraps, because the ROUND exit is taken at counter == 1.

Test Plan:
- NR=10, FIPS-197 C.1 (key 000102...0e0f), bench supplies expanded keys, in_data=69c4e0d86a7b0430d8cdb78070b4c55a.
  -> out_data=00112233445566778899aabbccddeeff, out_valid 11 edges after accept.
  -> rk_idx sequence 10,9,...,1,0.
- NR=10, FIPS-197 B (key 2b7e151628aed2a6abf7158809cf4f3c), in_data=3925841d02dc09fbdc118597196a0b32.
  -> out_data=3243f6a8885a308d313198a2e0370734.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid, with in_valid=1 and a second ciphertext waiting.
  -> out_data stable, in_ready=0, second block not accepted.
  -> Raise out_ready: second block accepted on that edge, its result arrives 11 edges later.
- Back-to-back: out_ready=1 and in_valid=1 continuously with C.1 then B vectors.
  -> Both plaintexts correct, spaced 11 cycles apart, no idle cycle between them.
- Reset mid-operation: assert rst for 1 cycle during round 5.
  -> Next cycle FSM=IDLE, out_valid=0, out_data=0, busy=0, in_ready=1.
  -> The subsequent C.1 decrypt is still correct.
- NR=14, FIPS-197 C.3 ciphertext 8ea2b7ca516745bfeafc49904b496089 with the AES-256 key schedule.
  -> out_data=00112233445566778899aabbccddeeff, latency 15 edges, rk_idx starts at 14.
